coproc0_unit: RTL
=================

# coproc0_unit

System-control coprocessor (CP0) for the unpipelined MIPS32 core. It sits directly downstream of the control path and consumes its `mc0`, `coproc0_we`, `eret` and `coproc0_invalid_instr` flags plus the ALU overflow. It holds Count, Compare, Status, Cause and EPC, prioritises exceptions and interrupts, and returns a PC redirect, a kill for the current instruction, and mfc0 read data.

## Interface

**Parameters**
- `EXC_VECTOR`, default `32'h0000_0180`: exception entry address.
- `COUNT_DIV`, default `1`: Count increments once every `COUNT_DIV` cycles (range 1..16).

**Ports**
- `i_clk` in 1: core clock.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_pc` in 32: PC of the instruction executing this cycle.
- `i_mc0` in 1: mfc0 in progress; selects `o_rdata` onto the write-back path.
- `i_coproc0_we` in 1: mtc0 write strobe.
- `i_reg_addr` in 5: CP0 register number (`rd` field, instruction[15:11]).
- `i_wdata` in 32: mtc0 data (`rt` value).
- `i_eret` in 1: eret executing.
- `i_invalid_instr` in 1: reserved-instruction flag.
- `i_overflow` in 1: ALU overflow, already qualified to add/sub/addi.
- `i_ext_int` in 6: level-sensitive external interrupt lines.
- `o_rdata` out 32: CP0 read data, combinational.
- `o_redirect` out 1: next PC must be `o_target`.
- `o_target` out 32: redirect address.
- `o_kill` out 1: suppress RegWr/MemWrite of the current instruction.
- `o_exl` out 1: Status.EXL.

## Operation

**Registers** (unimplemented numbers read 0 and ignore writes):
- **Count (9):** 32-bit, wraps `FFFF_FFFF`→0.
- **Compare (11):** 32-bit.
- **Status (12):** bit0 IE, bit1 EXL, [15:8] IM. Other bits read 0.
- **Cause (13):** [6:2] ExcCode, [15:8] IP. IP[7] = timer_pending | ext_int[5]; IP[6:2] = ext_int[4:0]; IP[1:0] are software bits, mtc0-writable. Other bits read 0.
- **EPC (14):** 32-bit, mtc0-writable.

**Timer**
- A prescaler counts 0..COUNT_DIV-1; Count increments when the prescaler wraps.
- timer_pending sets on the cycle Count == Compare (compared on the registered values).
- timer_pending clears on any mtc0 to Compare.

**Event priority**, evaluated combinationally each cycle, only while EXL=0:
1. RI (ExcCode 10) when `i_invalid_instr`.
2. Ov (ExcCode 12) when `i_overflow`.
3. Int (ExcCode 0) when IE & |(IP & IM) and `i_eret`=0.

**Taking an event**
- Asserts `o_redirect`=1, `o_target`=EXC_VECTOR.
- `o_kill`=1 for RI and Int. Ov also kills; the control path already drops RegWr for it.
- At the clock edge: EPC←i_pc, ExcCode←code, EXL←1.
- Any mtc0 in the same cycle is discarded.

**eret**
- `o_redirect`=1, `o_target`=EPC, `o_kill`=0.
- At the clock edge: EXL←0.

**Otherwise**
- `o_redirect`=0, `o_target`=`i_pc`+4 (don't-care).
- mtc0 updates the addressed register at the edge.

**Exceptions while EXL=1:** RI and Ov are ignored (no redirect, no state change). `o_kill` still asserts for RI.

## Timing

- All register state updates on the `i_clk` rising edge.
- `o_rdata`, `o_redirect`, `o_target` and `o_kill` are same-cycle combinational.
- mtc0 to Count loads `i_wdata`, suppresses the increment that cycle and resets the prescaler.
- mtc0 to EPC followed by eret in the next cycle returns to the new EPC.
- mfc0 of Count returns the pre-edge value.
- Reset (async, any time) clears Count, Compare, Status, Cause, EPC, the prescaler and timer_pending to 0; `o_exl`=0, `o_redirect`=0, `o_kill`=0.
- A reset asserted mid-exception cancels the EPC capture.

## Structure

- **Package `coproc0_pkg`:** register numbers (9, 11, 12, 13, 14), ExcCode constants (INT=0, RI=10, OV=12), Status/Cause bit positions.
- **Sub-module `coproc0_timer`:** prescaler, Count, Compare, timer_pending.
- **Top level:** priority logic, Status/Cause/EPC and the read mux.

## Test plan

- **Reset and timer:** reset, then idle 5 cycles with COUNT_DIV=1 → mfc0 $9 reads 5. With COUNT_DIV=2, after 10 cycles → reads 5.
- **Timer interrupt:** mtc0 Compare=20, Status=`32'h0000_8001` → in the cycle after Count hits 20: `o_redirect`=1, `o_target`=`32'h180`, EPC=`i_pc`, Cause[6:2]=0, EXL=1. Then mtc0 Compare → IP[7]=0.
- **RI:** `i_invalid_instr` at `i_pc`=`32'h40` → redirect to `32'h180`, ExcCode=10, EPC=`32'h40`. A following eret → `o_target`=`32'h40`, EXL=0.
- **Priority:** RI, overflow and a pending enabled interrupt in the same cycle → ExcCode=10, one redirect. Simultaneous mtc0 Status is discarded.
- **Masking:** `i_ext_int`=`6'b000001` with IM[2]=0 → no redirect. Set IM[2] → redirect. With EXL=1, overflow → no redirect, EPC unchanged.
- **Async reset:** reset pulse between clock edges during an exception cycle → all registers 0 immediately, no EPC update.

Source files
------------

// File: rtl/coproc0_pkg.sv
// CP0 shared definitions: register numbers, exception codes and the
// Status/Cause field positions.
package coproc0_pkg;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    typedef enum logic [4:0] {
        EXC_INT = 5'd0,
        EXC_RI  = 5'd10,
        EXC_OV  = 5'd12
    } exc_code_e;

    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LSB = 8;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_IP_LSB  = 8;

endpackage

// File: rtl/coproc0_timer.sv
// CP0 timer: prescaler, Count, Compare and the latched timer interrupt.
module coproc0_timer
    import coproc0_pkg::*;
#(
    parameter int COUNT_DIV = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        pending_o
);

    localparam logic [3:0] PRE_MAX = 4'(COUNT_DIV - 1);

    logic [3:0]  pre_q;
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        pend_q;

    // Count advances on prescaler wrap; an mtc0 to Count reloads it and restarts the prescaler.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            pend_q    <= 1'b0;
        end else begin
            if (count_we_i) begin
                count_q <= wdata_i;
                pre_q   <= '0;
            end else if (pre_q == PRE_MAX) begin
                count_q <= count_q + 32'd1;
                pre_q   <= '0;
            end else begin
                pre_q <= pre_q + 4'd1;
            end
            if (compare_we_i) begin
                compare_q <= wdata_i;
            end
            // A Compare write acknowledges the timer interrupt even if the match is live.
            if (compare_we_i) begin
                pend_q <= 1'b0;
            end else if (count_q == compare_q) begin
                pend_q <= 1'b1;
            end
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign pending_o = pend_q;

endmodule

// File: rtl/coproc0_unit.sv
// CP0 top: exception/interrupt priority, Status/Cause/EPC and mfc0 read mux.
module coproc0_unit
    import coproc0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
    parameter int          COUNT_DIV  = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_pc,
    input  logic        i_mc0,
    input  logic        i_coproc0_we,
    input  logic [4:0]  i_reg_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_eret,
    input  logic        i_invalid_instr,
    input  logic        i_overflow,
    input  logic [5:0]  i_ext_int,
    output logic [31:0] o_rdata,
    output logic        o_redirect,
    output logic [31:0] o_target,
    output logic        o_kill,
    output logic        o_exl
);

    logic        ie_q, ie_d;
    logic        exl_q, exl_d;
    logic [7:0]  im_q, im_d;
    logic [4:0]  exc_q, exc_d;
    logic [1:0]  ipsw_q, ipsw_d;
    logic [31:0] epc_q, epc_d;

    logic [31:0] count, compare;
    logic        timer_pend;
    logic [7:0]  ip;
    logic        int_req, take, do_eret, wr_en;
    exc_code_e   code;

    assign ip      = {timer_pend | i_ext_int[5], i_ext_int[4:0], ipsw_q};
    assign int_req = ie_q & (|(ip & im_q)) & ~i_eret;
    assign take    = ~exl_q & (i_invalid_instr | i_overflow | int_req);
    assign do_eret = i_eret & ~take;
    // An mtc0 issued alongside a taken event never retires.
    assign wr_en   = i_coproc0_we & ~take;

    coproc0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk_i        (i_clk),
        .rst_i        (i_rst),
        .count_we_i   (wr_en && i_reg_addr == REG_COUNT),
        .compare_we_i (wr_en && i_reg_addr == REG_COMPARE),
        .wdata_i      (i_wdata),
        .count_o      (count),
        .compare_o    (compare),
        .pending_o    (timer_pend)
    );

    // Priority encode the event cause: RI over Ov over Int.
    always_comb begin
        code = EXC_INT;
        if (i_invalid_instr) begin
            code = EXC_RI;
        end else if (i_overflow) begin
            code = EXC_OV;
        end
    end

    // Redirect, target and kill are same-cycle; reset forces them quiet.
    always_comb begin
        o_redirect = ~i_rst & (take | do_eret);
        o_kill     = ~i_rst & (take | i_invalid_instr);
        o_target   = i_pc + 32'd4;
        if (take) begin
            o_target = EXC_VECTOR;
        end else if (do_eret) begin
            o_target = epc_q;
        end
    end

    // Next state of Status/Cause/EPC: event entry, eret exit, or mtc0.
    always_comb begin
        ie_d   = ie_q;
        exl_d  = exl_q;
        im_d   = im_q;
        exc_d  = exc_q;
        ipsw_d = ipsw_q;
        epc_d  = epc_q;
        if (take) begin
            exl_d = 1'b1;
            exc_d = code;
            epc_d = i_pc;
        end else if (do_eret) begin
            exl_d = 1'b0;
        end else if (wr_en) begin
            case (i_reg_addr)
                REG_STATUS: begin
                    ie_d  = i_wdata[STATUS_IE];
                    exl_d = i_wdata[STATUS_EXL];
                    im_d  = i_wdata[STATUS_IM_LSB +: 8];
                end
                REG_CAUSE: ipsw_d = i_wdata[CAUSE_IP_LSB +: 2];
                REG_EPC:   epc_d  = i_wdata;
                default:   ;
            endcase
        end
    end

    // Architectural CP0 state, cleared asynchronously.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ie_q   <= 1'b0;
            exl_q  <= 1'b0;
            im_q   <= '0;
            exc_q  <= '0;
            ipsw_q <= '0;
            epc_q  <= '0;
        end else begin
            ie_q   <= ie_d;
            exl_q  <= exl_d;
            im_q   <= im_d;
            exc_q  <= exc_d;
            ipsw_q <= ipsw_d;
            epc_q  <= epc_d;
        end
    end

    // mfc0 read mux; unimplemented register numbers read zero.
    always_comb begin
        o_rdata = '0;
        case (i_reg_addr)
            REG_COUNT:   o_rdata = count;
            REG_COMPARE: o_rdata = compare;
            REG_STATUS: begin
                o_rdata[STATUS_IE]          = ie_q;
                o_rdata[STATUS_EXL]         = exl_q;
                o_rdata[STATUS_IM_LSB +: 8] = im_q;
            end
            REG_CAUSE: begin
                o_rdata[CAUSE_EXC_LSB +: 5] = exc_q;
                o_rdata[CAUSE_IP_LSB +: 8]  = ip;
            end
            REG_EPC:     o_rdata = epc_q;
            default:     o_rdata = '0;
        endcase
    end

    assign o_exl = exl_q;

endmodule
